lm07_multi_reader: RTL and testbench

Parametrised multi-sensor SPI temperature reader. It polls N_CH LM07-class sensors in round-robin order on a shared SCK/SIO bus, one chip select per sensor. For each sensor it extracts the signed integer temperature, converts the magnitude to BCD with a sequential shift-add converter, and stores a per-channel result. A 4-digit multiplexed 7-segment display shows sign, hundreds, tens and units for the channel chosen by DISP_SEL. It sits between the board sensor header and the display driver pins.

---
 rtl/lm07_multi_reader.sv | 168 ++++++++++++++++
 tb/tb_lm07_multi_reader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/lm07_multi_reader.sv
// lm07_multi_reader: round-robin SPI poller for LM07-class sensors with BCD conversion and 7-segment scan
module lm07_multi_reader #(
   parameter int N_CH       = 2,
   parameter int DATA_BITS  = 16,
   parameter int FRAC_SHIFT = 7,
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 8,
   parameter int SCAN_DIV   = 16
) (
   input  logic            SYSCLK,
   input  logic            RST,
   input  logic            SIO,
   output logic [N_CH-1:0] CS,
   output logic            SCK,
   input  logic [2:0]      DISP_SEL,
   output logic [8:0]      temp,
   output logic [N_CH-1:0] err,
   output logic            frame_done,
   output logic [2:0]      frame_ch,
   output logic [3:0]      disp,
   output logic [7:0]      dataSeg
);
   localparam int CHW = N_CH > 1 ? $clog2(N_CH) : 1;
   localparam int NS  = 1 << CHW;
   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, CONVERT, STORE} state_t;
   state_t               state_q, state_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [4:0]           bit_q, bit_d;
   logic [CHW-1:0]       ch_q, ch_d, sel;
   logic [DATA_BITS-1:0] frame_q, frame_d;
   logic [20:0]          dd_q, dd_d;
   logic [8:0]           val_q [NS];
   logic [8:0]           val_d [NS];
   logic [11:0]          bcd_q [NS];
   logic [11:0]          bcd_d [NS];
   logic [NS-1:0]        err_q, err_d;
   logic [15:0]          scan_q, scan_d;
   logic [1:0]           dig_q, dig_d;
   logic [8:0]           temp_q, temp_d, value, mag;
   logic [3:0]           disp_q, disp_d;
   logic [7:0]           seg_q, seg_d;
   logic [11:0]          adj, bcd_s;
   logic                 err_s;

   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: return 8'hFC;
         4'd1: return 8'h60;
         4'd2: return 8'hDA;
         4'd3: return 8'hF2;
         4'd4: return 8'h66;
         4'd5: return 8'hB6;
         4'd6: return 8'hBE;
         4'd7: return 8'hE0;
         4'd8: return 8'hFE;
         4'd9: return 8'hF6;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [3:0] add3(input logic [3:0] n);
      return n >= 4'd5 ? n + 4'd3 : n;
   endfunction

   always_ff @(posedge SYSCLK)
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
      end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      bit_d   = bit_q;
      case (state_q)
         IDLE:    if (cnt_q == 16'(GAP_CYCLES-1)) begin state_d = SETUP; cnt_d = '0; end
         SETUP:   if (cnt_q == 16'(CLK_DIV-1)) begin state_d = SHIFT; cnt_d = '0; bit_d = '0; end
         SHIFT:   if (cnt_q == 16'(2*CLK_DIV-1)) begin
                     cnt_d = '0;
                     bit_d = bit_q + 5'd1;
                     if (bit_q == 5'(DATA_BITS-1)) state_d = HOLD;
                  end
         HOLD:    if (cnt_q == 16'(CLK_DIV-1)) begin state_d = CONVERT; cnt_d = '0; end
         CONVERT: if (cnt_q == 16'd8) begin state_d = STORE; cnt_d = '0; end
         default: begin state_d = IDLE; cnt_d = '0; end
      endcase
   end

   always_comb begin
      CS         = state_q inside {SETUP, SHIFT, HOLD} ? ~(N_CH'(1) << ch_q) : '1;
      SCK        = state_q == SHIFT && cnt_q < 16'(CLK_DIV);
      frame_done = state_q == STORE;
      frame_ch   = 3'(ch_q);
   end

   // SIO is captured on the edge that raises SCK, i.e. whenever a new SHIFT bit period starts
   always_comb begin
      frame_d = state_d == SHIFT && cnt_d == '0 ? {frame_q[DATA_BITS-2:0], SIO} : frame_q;
      value   = 9'($signed(frame_q) >>> FRAC_SHIFT);
      mag     = value[8] ? 9'(-value) : value;
      adj     = {add3(dd_q[20:17]), add3(dd_q[16:13]), add3(dd_q[12:9])};
      dd_d    = state_q == HOLD ? {12'd0, mag} : state_q == CONVERT ? {adj, dd_q[8:0]} << 1 : dd_q;
      ch_d    = state_q == STORE ? (ch_q == CHW'(N_CH-1) ? '0 : ch_q + 1'b1) : ch_q;
      val_d   = val_q;
      bcd_d   = bcd_q;
      err_d   = err_q;
      if (state_q == STORE) begin
         err_d[ch_q] = &frame_q;
         if (!(&frame_q)) begin
            val_d[ch_q] = value;
            bcd_d[ch_q] = dd_q[20:9];
         end
      end
   end

   // display reads the next-state store so a fresh result shows the cycle after STORE
   always_comb begin
      sel    = {1'b0, DISP_SEL} < 4'(N_CH) ? DISP_SEL[CHW-1:0] : '0;
      scan_d = scan_q == 16'(SCAN_DIV-1) ? '0 : scan_q + 16'd1;
      dig_d  = scan_q == 16'(SCAN_DIV-1) ? dig_q + 2'd1 : dig_q;
      bcd_s  = bcd_d[sel];
      err_s  = err_d[sel];
      temp_d = val_d[sel];
      disp_d = 4'b0001 << dig_d;
      seg_d  = err_s ? 8'h02 :
               dig_d == 2'd0 ? seg7(bcd_s[3:0]) :
               dig_d == 2'd1 ? (bcd_s[11:4] == '0 ? 8'h00 : seg7(bcd_s[7:4])) :
               dig_d == 2'd2 ? (bcd_s[11:8] == '0 ? 8'h00 : seg7(bcd_s[11:8])) :
               (temp_d[8] ? 8'h02 : 8'h00);
   end

   always_ff @(posedge SYSCLK)
      if (RST) begin
         ch_q    <= '0;
         frame_q <= '0;
         dd_q    <= '0;
         val_q   <= '{default: '0};
         bcd_q   <= '{default: '0};
         err_q   <= '0;
         scan_q  <= '0;
         dig_q   <= '0;
         temp_q  <= '0;
         disp_q  <= 4'b0001;
         seg_q   <= 8'hFC;
      end else begin
         ch_q    <= ch_d;
         frame_q <= frame_d;
         dd_q    <= dd_d;
         val_q   <= val_d;
         bcd_q   <= bcd_d;
         err_q   <= err_d;
         scan_q  <= scan_d;
         dig_q   <= dig_d;
         temp_q  <= temp_d;
         disp_q  <= disp_d;
         seg_q   <= seg_d;
      end

   assign err     = err_q[N_CH-1:0];
   assign temp    = temp_q;
   assign disp    = disp_q;
   assign dataSeg = seg_q;
endmodule

// File: tb/tb_lm07_multi_reader.sv
// tb_lm07_multi_reader: directed bench with a serial sensor model and a 3-channel fast-clock instance
module tb_lm07_multi_reader;
   logic       SYSCLK = 0, RST = 1;
   logic       SIO;
   logic [1:0] CS, err;
   logic       SCK, frame_done;
   logic [2:0] DISP_SEL = 0, frame_ch;
   logic [8:0] temp;
   logic [3:0] disp;
   logic [7:0] dataSeg;
   logic [2:0] cs3, err3, fch3;
   logic       sck3, fd3;
   logic [8:0] temp3;
   logic [3:0] disp3;
   logic [7:0] seg3;
   logic [15:0] word0 = 16'h0C80, word1 = 16'hFFFF;
   int n_chk = 0, n_err = 0, cyc = 0, bitn = 0, fd_cnt = 0, fd0 = 0;
   int wins = 0, mon_bad = 0, nsck = 0, seq = 0;
   logic in_win = 0, sck_prev = 0;
   logic [2:0] win_cs = '1;
   logic cs_idle;
   localparam logic [2:0] SEQ [3] = '{3'b110, 3'b101, 3'b011};

   lm07_multi_reader dut (.SYSCLK(SYSCLK), .RST(RST), .SIO(SIO), .CS(CS), .SCK(SCK),
      .DISP_SEL(DISP_SEL), .temp(temp), .err(err), .frame_done(frame_done),
      .frame_ch(frame_ch), .disp(disp), .dataSeg(dataSeg));

   lm07_multi_reader #(.N_CH(3), .CLK_DIV(1)) u3 (.SYSCLK(SYSCLK), .RST(RST), .SIO(1'b0),
      .CS(cs3), .SCK(sck3), .DISP_SEL(3'd2), .temp(temp3), .err(err3), .frame_done(fd3),
      .frame_ch(fch3), .disp(disp3), .dataSeg(seg3));

   always #5 SYSCLK = ~SYSCLK;
   always @(posedge SYSCLK) cyc <= RST ? 0 : cyc + 1;

   // sensor model: bit n of the frame is presented until the n-th SCK rise
   assign cs_idle = &CS;
   always @(posedge SCK or posedge cs_idle) bitn <= cs_idle ? 0 : bitn + 1;
   always_comb begin
      SIO = 1'b1;
      if (bitn < 16) begin
         if (!CS[0]) SIO = word0[4'(15 - bitn)];
         else if (!CS[1]) SIO = word1[4'(15 - bitn)];
      end
   end

   always @(negedge SYSCLK) begin
      if (frame_done) fd_cnt++;
      if ($countones(~CS) > 1) mon_bad++;
      if (RST) begin
         in_win = 0; seq = 0; sck_prev = 0;
      end else begin
         if ($countones(~cs3) > 1) mon_bad++;
         if (sck3 && sck_prev) mon_bad++;
         if (!in_win && !(&cs3)) begin
            in_win = 1; nsck = 0; win_cs = cs3;
            if (cs3 !== SEQ[seq]) mon_bad++;
            seq = (seq + 1) % 3;
         end
         if (in_win && !(&cs3) && cs3 !== win_cs) mon_bad++;
         if (in_win && sck3 && !sck_prev) nsck++;
         if (in_win && &cs3) begin
            in_win = 0; wins++;
            if (nsck != 16) mon_bad++;
         end
         sck_prev = sck3;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic at(input int k);
      while (cyc < k) @(negedge SYSCLK);
   endtask

   task automatic seg_chk(input string tag, input int d, input logic [7:0] exp);
      int n = 0;
      while (disp !== 4'(1 << d) && n < 80) begin @(negedge SYSCLK); n++; end
      chk({tag, "_dig"}, 32'(disp), 32'(1 << d));
      chk(tag, 32'(dataSeg), 32'(exp));
   endtask

   initial begin
      repeat (3) @(posedge SYSCLK);
      @(negedge SYSCLK);
      chk("rst_cs", 32'(CS), 32'h3);
      chk("rst_sck", 32'(SCK), 0);
      chk("rst_fd", 32'(frame_done), 0);
      chk("rst_fch", 32'(frame_ch), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_temp", 32'(temp), 0);
      chk("rst_disp", 32'(disp), 32'h1);
      chk("rst_seg", 32'(dataSeg), 32'hFC);
      #1 RST = 0;
      at(7);   chk("gap_cs", 32'(CS), 32'h3);
      at(8);   chk("cs0_fall", 32'(CS), 32'h2); chk("setup_sck", 32'(SCK), 0);
      at(12);  chk("sck_rise", 32'(SCK), 1);
      at(152); chk("fd_early", 32'(frame_done), 0);
      at(153); chk("fd_first", 32'(frame_done), 1); chk("fch_first", 32'(frame_ch), 0);
      at(154); chk("temp_25", 32'(temp), 25); chk("disp_phase", 32'(disp), 32'h2);
      seg_chk("p25_units", 0, 8'hB6);
      seg_chk("p25_tens", 1, 8'hDA);
      seg_chk("p25_hund", 2, 8'h00);
      seg_chk("p25_sign", 3, 8'h00);
      at(250); #1 word0 = 16'hF380;
      at(307); chk("fd_ch1", 32'(frame_done), 1); chk("fch_ch1", 32'(frame_ch), 1);
      at(308); chk("err_set", 32'(err), 32'h2);
      #1 DISP_SEL = 1;
      at(309); chk("err_seg", 32'(dataSeg), 32'h02); chk("err_temp", 32'(temp), 0);
      seg_chk("err_units", 0, 8'h02);
      at(340); #1 DISP_SEL = 5;
      at(341); chk("sel_range", 32'(temp), 25);
      #1 DISP_SEL = 0;
      at(350); #1 word1 = 16'h4B00;
      at(460); chk("pre_store", 32'(temp), 25);
      at(461); chk("store_cyc", 32'(temp), 25);
      at(462); chk("temp_m25", 32'(temp), 32'h1E7); chk("m25_units", 32'(dataSeg), 32'hB6);
      seg_chk("m25_tens", 1, 8'hDA);
      seg_chk("m25_hund", 2, 8'h00);
      seg_chk("m25_sign", 3, 8'h02);
      at(520); #1 word0 = 16'h0000;
      at(616); chk("err_clr", 32'(err), 0);
      #1 DISP_SEL = 1;
      at(617); chk("temp_150", 32'(temp), 150);
      seg_chk("p150_hund", 2, 8'h60);
      seg_chk("p150_sign", 3, 8'h00);
      seg_chk("p150_units", 0, 8'hFC);
      seg_chk("p150_tens", 1, 8'hB6);
      #1 DISP_SEL = 0;
      at(770); chk("temp_0", 32'(temp), 0);
      seg_chk("z_units", 0, 8'hFC);
      seg_chk("z_tens", 1, 8'h00);
      seg_chk("z_hund", 2, 8'h00);
      seg_chk("z_sign", 3, 8'h00);
      at(820); #1 word0 = 16'h0C80;
      at(830); #1 DISP_SEL = 1;
      at(831); chk("pre_rst_temp", 32'(temp), 150);
      at(840); #1 RST = 1;
      @(negedge SYSCLK);
      chk("mid_rst_cs", 32'(CS), 32'h3);
      chk("mid_rst_sck", 32'(SCK), 0);
      chk("mid_rst_temp", 32'(temp), 0);
      chk("mid_rst_fd", 32'(frame_done), 0);
      fd0 = fd_cnt;
      #1 RST = 0; DISP_SEL = 0;
      at(7);   chk("re_gap_cs", 32'(CS), 32'h3);
      at(8);   chk("re_cs0", 32'(CS), 32'h2);
      at(152); chk("no_partial_fd", 32'(fd_cnt - fd0), 0);
      at(153); chk("re_fd", 32'(frame_done), 1); chk("re_fch", 32'(frame_ch), 0);
      at(154); chk("re_temp", 32'(temp), 25);
      chk("n3_windows", 32'(wins >= 10), 1);
      chk("bus_monitor", 32'(mon_bad), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
